vscpu_memory: RTL and testbench

- Single-port 64 x 8 unified program/data RAM for the VSCPU.
- Attaches to the control unit through `addr` (driven by AR), the `READ`/`WRITE` strobes and a shared bidirectional 8-bit `data` line.
- Reads are combinational and drive the tri-state line; writes commit on the rising clock edge.
- Asynchronous reset puts the array into a known image.

---
 rtl/vscpu_memory.sv | 56 +++++
 tb/tb_vscpu_memory.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vscpu_memory.sv
// vscpu_memory: single-port 64 x 8 unified program/data RAM for the VSCPU.
//   Latency: reads are combinational (zero cycles); writes commit on the rising edge of clk.
//   No handshake: data is driven only while READ=1, WRITE=0, reset=0; otherwise high-Z.
//
// Ports:
//   clk    - system clock; writes commit on its rising edge
//   reset  - asynchronous, active-high; loads the reset image into every word
//   addr   - word address (AR[5:0])
//   WRITE  - write strobe, active high; takes priority over READ
//   READ   - read strobe, active high
//   data   - shared bidirectional data line
//
// Build option: define VSCPU_MEM_BOOTROM_EN to preload a four-word boot
// program at addresses 0x00..0x03 on reset (all other words reset to 0x00).
// Without it the whole array resets to 0x00.

module vscpu_memory #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic              WRITE,
  input  logic              READ,
  inout  wire  [DATA_W-1:0] data
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              drive;

  // The reset branch also wins over a write strobe that is up when reset
  // arrives, so a write interrupted by reset leaves the reset image in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
`ifdef VSCPU_MEM_BOOTROM_EN
      // Boot program: CLEAR, FLIP, STORE 0x3F, NAND 0x3F.
      mem[0] <= DATA_W'(8'h00);
      mem[1] <= DATA_W'(8'h40);
      mem[2] <= DATA_W'(8'hFF);
      mem[3] <= DATA_W'(8'hBF);
`endif
    end else if (WRITE) begin
      mem[addr] <= data;
    end
  end

  // WRITE excludes driving so a simultaneous READ never fights the writer.
  assign drive = READ && !WRITE && !reset;
  assign data  = drive ? mem[addr] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_vscpu_memory.sv
// tb_vscpu_memory: directed test of vscpu_memory with a queued scoreboard.
//   The data line has a pull-up, so a released (high-Z) line reads 0xFF;
//   high-Z checks are made at addresses whose stored value is not 0xFF.

module tb_vscpu_memory;

  logic       clk;
  logic       reset;
  logic [5:0] addr;
  logic       write_en;
  logic       read_en;
  logic [7:0] drv;
  logic       drv_en;
  tri1  [7:0] data;

  assign data = drv_en ? drv : 8'hzz;

  vscpu_memory dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .WRITE (write_en),
    .READ  (read_en),
    .data  (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: stimulus pushes expected values, the monitor pops and compares.
  logic [7:0] exp_q  [$];
  string      name_q [$];
  int         checks = 0;
  int         errors = 0;

  initial begin : monitor
    logic [7:0] e;
    string      n;
    forever begin
      wait (exp_q.size() != 0);
      #1;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (data !== e) begin
        errors++;
        $display("FAIL %s: got 0x%02h, expected 0x%02h (t=%0t)", n, data, e, $time);
      end
    end
  end

  function automatic logic [7:0] image(input int a);
`ifdef VSCPU_MEM_BOOTROM_EN
    case (a)
      1:       return 8'h40;
      2:       return 8'hFF;
      3:       return 8'hBF;
      default: return 8'h00;
    endcase
`else
    if (a < 0) return 8'h01;
    return 8'h00;
`endif
  endfunction

  task automatic expect_now(input logic [7:0] e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    #3;
  endtask

  task automatic rd(input logic [5:0] a, input logic [7:0] e, input string n);
    addr     = a;
    read_en  = 1'b1;
    write_en = 1'b0;
    drv_en   = 1'b0;
    expect_now(e, n);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    @(negedge clk);
    addr     = a;
    read_en  = 1'b0;
    write_en = 1'b1;
    drv      = d;
    drv_en   = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
    drv_en   = 1'b0;
  endtask

  initial begin : watchdog
    #20000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset    = 1'b1;
    addr     = 6'h01;
    write_en = 1'b0;
    read_en  = 1'b1;
    drv      = 8'h00;
    drv_en   = 1'b0;

    // Reset: line released even with READ high.
    #1;
    expect_now(8'hFF, "reset_hiz");
    #9;
    reset = 1'b0;               // released between edges (t=13)

    // Reset image over the whole array.
    for (int a = 0; a < 64; a++) begin
      rd(6'(a), image(a), $sformatf("image[%0d]", a));
    end

    // Single write, then same-cycle read and neighbours untouched.
    wr(6'h15, 8'hA5);
    rd(6'h15, 8'hA5, "wr_0x15");
    rd(6'h14, 8'h00, "nbr_0x14");
    rd(6'h16, 8'h00, "nbr_0x16");

    // Idle: high-Z while mem[0x15]=0xA5.
    @(negedge clk);
    addr = 6'h15; read_en = 1'b0; write_en = 1'b0; drv_en = 1'b0;
    expect_now(8'hFF, "idle_hiz");

    // READ and WRITE together: memory stays off the line, bench value lands.
    @(negedge clk);
    addr = 6'h15; read_en = 1'b1; write_en = 1'b1; drv_en = 1'b0;
    expect_now(8'hFF, "rw_hiz");
    drv = 8'h3C; drv_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0; drv_en = 1'b0;
    rd(6'h15, 8'h3C, "rw_write");

    // Combinational address tracking at both ends of the array.
    wr(6'h3F, 8'h11);
    wr(6'h00, 8'h22);
    rd(6'h3F, 8'h11, "trk_0x3F_a");
    rd(6'h00, 8'h22, "trk_0x00_a");
    rd(6'h3F, 8'h11, "trk_0x3F_b");
    rd(6'h00, 8'h22, "trk_0x00_b");

    // Reset arriving before the write edge wins.
    @(negedge clk);
    addr = 6'h20; read_en = 1'b0; write_en = 1'b1; drv = 8'h77; drv_en = 1'b1;
    #2 reset = 1'b1;
    #4 write_en = 1'b0; drv_en = 1'b0;  // posedge passed under reset
    #1 reset = 1'b0;
    rd(6'h20, 8'h00, "rst_mid_write");
    rd(6'h15, image(21), "rst_clears_0x15");
    rd(6'h3F, image(63), "rst_clears_0x3F");
    rd(6'h00, image(0), "rst_reloads_0x00");
    rd(6'h01, image(1), "rst_reloads_0x01");

    // First edge after reset release accepts a write.
    wr(6'h20, 8'h5A);
    rd(6'h20, 8'h5A, "post_rst_write");

    // Drain the scoreboard before reporting.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
